div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div.sv | 148 ++++++++++++++
 tb/tb_div.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or unsigned,
// result {remainder, quotient} registered with a ready flag.
module div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [WIDTH-1:0]   r_rem, w_rem_nx;
  logic [WIDTH-1:0]   r_dvd, w_dvd_nx;
  logic [WIDTH-1:0]   r_divisor, w_divisor_nx;
  logic               r_signed, w_signed_nx;
  logic               r_neg1, w_neg1_nx;
  logic               r_neg2, w_neg2_nx;
  logic [2*WIDTH-1:0] r_result, w_result_nx;
  logic               r_ready, w_ready_nx;

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_abs1, w_abs2, w_quo, w_remf;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return -x;
  endfunction

  // The extra top bit keeps the compare exact for unsigned divisors with MSB set.
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_divisor};
  assign w_abs1  = (signed_div_i && opdata1_i[WIDTH-1]) ? neg(opdata1_i) : opdata1_i;
  assign w_abs2  = (signed_div_i && opdata2_i[WIDTH-1]) ? neg(opdata2_i) : opdata2_i;
  assign w_quo   = (r_signed && (r_neg1 != r_neg2)) ? neg(r_dvd) : r_dvd;
  assign w_remf  = (r_signed && r_neg1) ? neg(r_rem) : r_rem;

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_rem_nx     = r_rem;
    w_dvd_nx     = r_dvd;
    w_divisor_nx = r_divisor;
    w_signed_nx  = r_signed;
    w_neg1_nx    = r_neg1;
    w_neg2_nx    = r_neg2;
    w_result_nx  = r_result;
    w_ready_nx   = r_ready;
    unique case (r_state)
      S_FREE: begin
        w_result_nx = '0;
        w_ready_nx  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nx = S_BYZERO;
          end else begin
            w_state_nx   = S_ON;
            w_signed_nx  = signed_div_i;
            w_neg1_nx    = signed_div_i && opdata1_i[WIDTH-1];
            w_neg2_nx    = signed_div_i && opdata2_i[WIDTH-1];
            w_divisor_nx = w_abs2;
            w_dvd_nx     = w_abs1;
            w_rem_nx     = '0;
            w_cnt_nx     = '0;
          end
        end
      end
      S_BYZERO: begin
        w_result_nx = '0;
        if (annul_i) begin
          w_state_nx = S_FREE;
          w_ready_nx = 1'b0;
        end else begin
          w_state_nx = S_END;
          w_ready_nx = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          w_state_nx  = S_FREE;
          w_result_nx = '0;
          w_ready_nx  = 1'b0;
        end else if (r_cnt != CNT_W'(WIDTH)) begin
          if (w_shift >= {1'b0, r_divisor}) begin
            w_rem_nx = w_diff[WIDTH-1:0];
            w_dvd_nx = {r_dvd[WIDTH-2:0], 1'b1};
          end else begin
            w_rem_nx = w_shift[WIDTH-1:0];
            w_dvd_nx = {r_dvd[WIDTH-2:0], 1'b0};
          end
          w_cnt_nx = r_cnt + CNT_W'(1);
        end else begin
          w_state_nx  = S_END;
          w_result_nx = {w_remf, w_quo};
          w_ready_nx  = 1'b1;
        end
      end
      S_END: begin
        if (!start_i) begin
          w_state_nx  = S_FREE;
          w_result_nx = '0;
          w_ready_nx  = 1'b0;
        end
      end
      default: w_state_nx = S_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FREE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_divisor <= '0;
      r_signed  <= 1'b0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_rem     <= w_rem_nx;
      r_dvd     <= w_dvd_nx;
      r_divisor <= w_divisor_nx;
      r_signed  <= w_signed_nx;
      r_neg1    <= w_neg1_nx;
      r_neg2    <= w_neg2_nx;
      r_result  <= w_result_nx;
      r_ready   <= w_ready_nx;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Directed/scoreboard bench for the multi-cycle divider (WIDTH=32).
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  div #(.WIDTH(32)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division, remainder follows dividend, MIN/-1 wraps.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) return 64'd0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  // mode 0: normal; 1: start/operands wiggled mid-divide; 2: async reset while results shown
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_lat, input int mode);
    int edges;
    bit got;
    logic [63:0] exp;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    sb_q.push_back(exp_res);
    edges = 0;
    got   = 0;
    while (edges < 100 && !got) begin
      @(posedge clk); #1;
      edges++;
      if (mode == 1 && edges == 4) begin
        start_i   = 1'b0;
        opdata1_i = ~a;
        opdata2_i = b + 32'd5;
      end
      if (mode == 1 && edges == 7) start_i = 1'b1;
      if (ready_o) got = 1;
    end
    check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check({tag, "_result"}, result_o, exp);
    @(posedge clk); #1;
    check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
    check({tag, "_hold_result"}, result_o, exp);
    if (mode == 2) begin
      #3 rst = 1'b0;
      #1;
      check({tag, "_rst_ready"}, 64'(ready_o), 64'd0);
      check({tag, "_rst_result"}, result_o, 64'd0);
      start_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
    end else begin
      start_i = 1'b0;
      @(posedge clk); #1;
      check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
      check({tag, "_drop_result"}, result_o, 64'd0);
    end
  endtask

  initial begin
    bit rose;
    logic [31:0] ra, rb;
    logic rs;
    rst = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    #12;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_div("u100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                      34, 0);
    run_div("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},       34, 0);
    run_div("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD},       34, 0);
    run_div("u_big",    1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  {32'h7FFF_FFFF, 32'h0000_0001},       34, 0);
    run_div("s_min_-1", 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0, 32'h8000_0000},               34, 0);
    run_div("by_zero",  1'b1, 32'd1234,       32'd0,          64'd0,                                2,  0);
    run_div("toggle",   1'b0, 32'd1000,       32'd9,          {32'd1, 32'd111},                     34, 1);
    run_div("rst_end",  1'b0, 32'd77,         32'd10,         {32'd7, 32'd7},                       34, 2);

    // Abort after ten iterations; no result may ever appear.
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (11) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_result", result_o, 64'd0);
    rose = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ready_o) rose = 1;
    end
    check("annul_never_ready", 64'(rose), 64'd0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 0);

    // start and annul together in FREE must not begin a divide.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    annul_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("annul_start_ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    run_div("after_annul_start", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 0);

    // Asynchronous reset at iteration 20, then a full-latency divide.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (21) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run_div("u50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 34, 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 32'd0) rb = 32'd3;
      rs = i[0];
      run_div("random", rs, ra, rb, model(rs, ra, rb), 34, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
